lcd_sequencer: RTL and testbench
================================

Name: lcd_sequencer

Overview:
Owns the Spartan-3E character LCD's 4-bit write-only bus. After reset it runs the HD44780 power-on initialisation and configuration autonomously. It then accepts command and data bytes from a client over a valid/ready handshake, splits each byte into two nibbles and generates E strobes with the required setup, pulse-width and execution delays. It replaces the free-running count-slice sequencing with a cycle-exact, request-driven engine.

Parameters:
T_POWERUP, 750000, cycles of idle wait after reset release (15 ms @ 50 MHz)
T_INIT1, 205000, wait after 1st init nibble (4.1 ms)
T_INIT2, 5000, wait after 2nd init nibble (100 us)
T_CMD, 2000, wait after a byte's low nibble and after init nibbles 3-4 (40 us)
T_CLEAR, 82000, wait after clear/home commands (1.64 ms)
T_NIBBLE, 50, wait between the high and low nibble of a byte (1 us)
T_EHIGH, 12, E high width in cycles (240 ns)
T_SETUP, 2, RS/data setup before E rises

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  client has a byte to send
req_ready  out  1  sequencer accepts a byte this cycle
req_rs  in  1  0 = instruction, 1 = data
req_data  in  8  byte to write
init_done  out  1  power-on init and configuration complete
busy  out  1  high whenever not in IDLE
sf_e  out  1  LCD/StrataFlash select, 1 = LCD
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  register select
lcd_rw  out  1  read/write (write only)
lcd_d  out  4  LCD data nibble

Behaviour:
- Reset (async, rst_n=0): sf_e=1, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, req_ready=0, init_done=0, busy=1; FSM -> PWR_WAIT, counters cleared. Reset mid-transfer aborts it. The full power-up sequence restarts on release.
- lcd_rw is constant 0. sf_e is constant 1. All outputs are registered.
- Nibble engine, used for every nibble:
  - SETUP: lasts T_SETUP cycles. lcd_rs/lcd_d load on entry; lcd_e=0.
  - EHIGH: lasts T_EHIGH cycles; lcd_e=1.
  - WAIT: lasts N cycles; lcd_e=0.
  - lcd_rs/lcd_d hold their values from SETUP entry until the next SETUP entry.
- PWR_WAIT: T_POWERUP cycles after rst_n release, then the init sequence.
- Init sequence: nibbles with rs=0:
  - 0x3, N=T_INIT1
  - 0x3, N=T_INIT2
  - 0x3, N=T_CMD
  - 0x2, N=T_CMD
- Configuration: bytes with rs=0, sent via the byte path: 0x28 (function set), 0x06 (entry mode), 0x0C (display on), 0x01 (clear).
- Byte path:
  - High nibble (data[7:4]), N=T_NIBBLE.
  - Low nibble (data[3:0]), N=T_CMD, except rs=0 with data in {0x01,0x02,0x03}, which uses N=T_CLEAR.
- After the clear wait ends: init_done=1 (sticky until reset), FSM -> IDLE.
- IDLE: req_ready=1, busy=0.
  - Transfer occurs when req_valid and req_ready are both high at a clk edge. req_rs/req_data are captured; the next cycle req_ready=0, busy=1 and the FSM enters the high-nibble SETUP.
  - After the low-nibble WAIT completes, return to IDLE; req_ready=1 the same cycle IDLE is entered.
  - Back-to-back requests are allowed: a request accepted on the first IDLE cycle starts immediately.
- req_valid while req_ready=0 (init or busy) is ignored, with no capture. The client must hold it; the sequencer does not queue.
- Counter widths are sized from the largest parameter (clog2). Each wait lasts exactly the parameter count: no ±1 slack, and no zero-length states except T_SETUP=0, which skips SETUP.

Test Plan:
Use params T_POWERUP=20, T_INIT1=10, T_INIT2=6, T_CMD=4, T_CLEAR=15, T_NIBBLE=3, T_EHIGH=2, T_SETUP=1 for all scenarios.
1. Release rst_n -> lcd_e stays 0 for 21 cycles; first lcd_e rise at cycle 21 with lcd_d=0x3, lcd_rs=0; E high exactly 2 cycles; sf_e=1 throughout.
2. Full init -> exactly 12 E pulses with nibbles 3,3,3,2,2,8,0,6,0,C,0,1. Gaps after E falls: 10,6,4,4,3,4,3,4,3,4,3,15. Then init_done=1 and req_ready=1.
3. After init, write rs=1 data=0x48 ('H') -> req_ready drops next cycle. Pulses lcd_d=0x4 then 0x8 with lcd_rs=1, 3-cycle gap between them. req_ready returns 4 cycles after the second E falls.
4. rs=0 data=0x01 and rs=0 data=0xC0 -> 0x01 low-nibble wait is 15 cycles; 0xC0 uses 4.
5. req_valid held high during init and throughout a busy transfer -> no capture until req_ready=1. Exactly one transfer per handshake. Back-to-back bytes produce no lost or duplicated nibbles.
6. Assert rst_n=0 during EHIGH of a data byte -> lcd_e falls asynchronously; all outputs take reset values; on release the 21-cycle power-up wait and full init repeat.

Source files
------------

// File: rtl/lcd_req_if.sv
// Client-to-sequencer byte request channel for the character LCD.
// A byte moves on a rising clk edge where req_valid and req_ready are both high.
interface lcd_req_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rs;
  logic [7:0] req_data;

  modport master (output req_valid, output req_rs, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_sequencer.sv
// HD44780 4-bit write sequencer: power-on init, configuration, then client bytes
// split into nibbles with cycle-exact setup, E-high and execution waits.
module lcd_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned T_NIBBLE  = 50,
  parameter int unsigned T_EHIGH   = 12,
  parameter int unsigned T_SETUP   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_req_if.slave   req,
  output logic       init_done,
  output logic       busy,
  output logic       sf_e,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d,
  output logic [2:0] dbg_state
);
  localparam int unsigned M0 = (T_POWERUP > T_INIT1) ? T_POWERUP : T_INIT1;
  localparam int unsigned M1 = (M0 > T_INIT2) ? M0 : T_INIT2;
  localparam int unsigned M2 = (M1 > T_CMD) ? M1 : T_CMD;
  localparam int unsigned M3 = (M2 > T_CLEAR) ? M2 : T_CLEAR;
  localparam int unsigned M4 = (M3 > T_NIBBLE) ? M3 : T_NIBBLE;
  localparam int unsigned M5 = (M4 > T_EHIGH) ? M4 : T_EHIGH;
  localparam int unsigned T_MAX = (M5 > T_SETUP) ? M5 : T_SETUP;
  localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  // seq: 0-3 init nibbles, 4-11 configuration nibbles, 12/13 client high/low nibble
  localparam logic [3:0] SEQ_CFG_LAST = 4'd11;
  localparam logic [3:0] SEQ_USER_HI  = 4'd12;
  localparam logic [3:0] SEQ_USER_LO  = 4'd13;

  typedef enum logic [2:0] {PWR_WAIT, SETUP, EHIGH, WAIT, IDLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    seq, seq_n;
  logic          cap_rs, cap_rs_n;
  logic [7:0]    cap_data, cap_data_n;
  logic          rs_q, rs_n;
  logic [3:0]    d_q, d_n;
  logic          done_q, done_n;
  logic          e_q, e_n;
  logic          ready_q, ready_n;
  logic          busy_q, busy_n;
  logic          start, accept;
  logic [3:0]    start_seq;
  logic          start_rs;
  logic [7:0]    start_byte;
  logic          cur_rs;
  logic [7:0]    cur_byte;

  function automatic logic [CW-1:0] last_of(int unsigned len);
    return CW'(len - 1);
  endfunction

  function automatic logic [7:0] cfg_byte(logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] byte_for(logic [3:0] s, logic [7:0] cap);
    logic [3:0] off;
    off = s - 4'd4;
    if (s >= SEQ_USER_HI) return cap;
    return cfg_byte(off[2:1]);
  endfunction

  function automatic logic [3:0] nib_of(logic [3:0] s, logic [7:0] b);
    if (s < 4'd3) return 4'h3;
    if (s == 4'd3) return 4'h2;
    return s[0] ? b[3:0] : b[7:4];
  endfunction

  // Clear/home style instructions need the long execution wait on their low nibble.
  function automatic logic [CW-1:0] wait_last(logic [3:0] s, logic rs, logic [7:0] b);
    if (s == 4'd0) return last_of(T_INIT1);
    if (s == 4'd1) return last_of(T_INIT2);
    if (s < 4'd4) return last_of(T_CMD);
    if (!s[0]) return last_of(T_NIBBLE);
    if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return last_of(T_CLEAR);
    return last_of(T_CMD);
  endfunction

  assign cur_rs   = (seq >= SEQ_USER_HI) ? cap_rs : 1'b0;
  assign cur_byte = byte_for(seq, cap_data);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    seq_n      = seq;
    cap_rs_n   = cap_rs;
    cap_data_n = cap_data;
    rs_n       = rs_q;
    d_n        = d_q;
    done_n     = done_q;
    start      = 1'b0;
    accept     = 1'b0;
    start_seq  = seq;
    case (state)
      PWR_WAIT: begin
        if (cnt == last_of(T_POWERUP)) begin
          start     = 1'b1;
          start_seq = 4'd0;
        end
      end
      SETUP: begin
        if (cnt == last_of(T_SETUP)) begin
          state_n = EHIGH;
          cnt_n   = '0;
        end
      end
      EHIGH: begin
        if (cnt == last_of(T_EHIGH)) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (cnt == wait_last(seq, cur_rs, cur_byte)) begin
          if (seq == SEQ_CFG_LAST || seq == SEQ_USER_LO) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (seq == SEQ_CFG_LAST) done_n = 1'b1;
          end else begin
            start     = 1'b1;
            start_seq = seq + 4'd1;
          end
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (req.req_valid && ready_q) begin
          accept     = 1'b1;
          start      = 1'b1;
          start_seq  = SEQ_USER_HI;
          cap_rs_n   = req.req_rs;
          cap_data_n = req.req_data;
        end
      end
      default: begin
        state_n = PWR_WAIT;
        cnt_n   = '0;
      end
    endcase

    start_rs   = accept ? req.req_rs : ((start_seq >= SEQ_USER_HI) ? cap_rs : 1'b0);
    start_byte = accept ? req.req_data : byte_for(start_seq, cap_data);
    if (start) begin
      seq_n   = start_seq;
      cnt_n   = '0;
      rs_n    = start_rs;
      d_n     = nib_of(start_seq, start_byte);
      state_n = (T_SETUP == 0) ? EHIGH : SETUP;
    end

    // Outputs are registered from the next state so they line up with the state register.
    e_n     = (state_n == EHIGH);
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PWR_WAIT;
      cnt      <= '0;
      seq      <= '0;
      cap_rs   <= 1'b0;
      cap_data <= '0;
      rs_q     <= 1'b0;
      d_q      <= '0;
      done_q   <= 1'b0;
      e_q      <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      seq      <= seq_n;
      cap_rs   <= cap_rs_n;
      cap_data <= cap_data_n;
      rs_q     <= rs_n;
      d_q      <= d_n;
      done_q   <= done_n;
      e_q      <= e_n;
      ready_q  <= ready_n;
      busy_q   <= busy_n;
    end
  end

  assign req.req_ready = ready_q;
  assign init_done     = done_q;
  assign busy          = busy_q;
  assign sf_e          = 1'b1;
  assign lcd_rw        = 1'b0;
  assign lcd_e         = e_q;
  assign lcd_rs        = rs_q;
  assign lcd_d         = d_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: a timeline model of the LCD pins checked every cycle,
// plus hand-computed pulse/gap expectations for init, data, clear and reset.
module tb_lcd_sequencer;
  localparam int unsigned P_POWERUP = 20;
  localparam int unsigned P_INIT1   = 10;
  localparam int unsigned P_INIT2   = 6;
  localparam int unsigned P_CMD     = 4;
  localparam int unsigned P_CLEAR   = 15;
  localparam int unsigned P_NIBBLE  = 3;
  localparam int unsigned P_EHIGH   = 2;
  localparam int unsigned P_SETUP   = 1;
  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init_done, busy, sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  lcd_req_if rq();

  lcd_sequencer #(
    .T_POWERUP(P_POWERUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2), .T_CMD(P_CMD),
    .T_CLEAR(P_CLEAR), .T_NIBBLE(P_NIBBLE), .T_EHIGH(P_EHIGH), .T_SETUP(P_SETUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(rq), .init_done(init_done), .busy(busy),
    .sf_e(sf_e), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d),
    .dbg_state(dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           in_reset = 1'b1;
  bit           m_done = 1'b0;
  logic         m_rs = 1'b0;
  logic [3:0]   m_d = 4'h0;
  int           cyc = 0;
  int           hs_cyc = 0;
  int           rise_q[$], fall_q[$], rdy_rise_q[$], rdy_fall_q[$];
  logic [3:0]   nib_q[$];
  logic         rsl_q[$];
  logic         prev_e = 1'b0, prev_rdy = 1'b0;

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Record layout: {sf_e, lcd_rw, lcd_e, lcd_rs, lcd_d, req_ready, busy, init_done}
  function automatic logic [W-1:0] rec(logic e, logic rs, logic [3:0] d,
                                       logic rdy, logic bsy, logic dn);
    return {1'b1, 1'b0, e, rs, d, rdy, bsy, dn};
  endfunction

  task automatic push_nib(logic rs, logic [3:0] d, int unsigned n);
    repeat (P_SETUP) exp_q.push_back(rec(1'b0, rs, d, 1'b0, 1'b1, m_done));
    repeat (P_EHIGH) exp_q.push_back(rec(1'b1, rs, d, 1'b0, 1'b1, m_done));
    repeat (n)       exp_q.push_back(rec(1'b0, rs, d, 1'b0, 1'b1, m_done));
    m_rs = rs;
    m_d  = d;
  endtask

  task automatic push_byte(logic rs, logic [7:0] b);
    push_nib(rs, b[7:4], P_NIBBLE);
    push_nib(rs, b[3:0], (!rs && b >= 8'h01 && b <= 8'h03) ? P_CLEAR : P_CMD);
  endtask

  task automatic push_init();
    m_done = 1'b0;
    m_rs   = 1'b0;
    m_d    = 4'h0;
    repeat (P_POWERUP) exp_q.push_back(rec(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0));
    push_nib(1'b0, 4'h3, P_INIT1);
    push_nib(1'b0, 4'h3, P_INIT2);
    push_nib(1'b0, 4'h3, P_CMD);
    push_nib(1'b0, 4'h2, P_CMD);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
    m_done = 1'b1;
  endtask

  // Compare process: one expected record per clock, idle record when the model has nothing pending.
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    got = {sf_e, lcd_rw, lcd_e, lcd_rs, lcd_d, rq.req_ready, busy, init_done};
    if (in_reset) want = rec(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    else if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = rec(1'b0, m_rs, m_d, 1'b1, 1'b0, 1'b1);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL pins cyc=%0d got=%b expected=%b", cyc, got, want);
    end
    if (!in_reset) begin
      if (lcd_e && !prev_e) begin
        rise_q.push_back(cyc);
        nib_q.push_back(lcd_d);
        rsl_q.push_back(lcd_rs);
      end
      if (!lcd_e && prev_e) fall_q.push_back(cyc);
      if (rq.req_ready && !prev_rdy) rdy_rise_q.push_back(cyc);
      if (!rq.req_ready && prev_rdy) rdy_fall_q.push_back(cyc);
      cyc++;
    end
    prev_e   = lcd_e;
    prev_rdy = rq.req_ready;
  end

  task automatic wait_empty(string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk(name, 0, 1);
  endtask

  task automatic drive_byte(logic rs, logic [7:0] b, bit keep_valid);
    bit ok;
    rq.req_valid = 1'b1;
    rq.req_rs    = rs;
    rq.req_data  = b;
    wait_empty("handshake_timeout", ok);
    if (ok) begin
      hs_cyc = cyc;
      exp_q.push_back(rec(1'b0, m_rs, m_d, 1'b1, 1'b0, 1'b1));
      push_byte(rs, b);
    end
    @(posedge clk); #1;
    if (!keep_valid) rq.req_valid = 1'b0;
  endtask

  task automatic wait_idle(int n);
    bit ok;
    wait_empty("idle_timeout", ok);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic release_reset();
    exp_q.delete();
    rise_q.delete();
    fall_q.delete();
    rdy_rise_q.delete();
    rdy_fall_q.delete();
    nib_q.delete();
    rsl_q.delete();
    cyc      = 0;
    in_reset = 1'b0;
    rst_n    = 1'b1;
    push_init();
  endtask

  task automatic check_init(string tag);
    int exp_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
    int exp_gap[12] = '{10, 6, 4, 4, 3, 4, 3, 4, 3, 4, 3, 15};
    chk({tag, "_first_rise"}, rise_q[0], 21);
    chk({tag, "_first_rs"}, int'(rsl_q[0]), 0);
    chk({tag, "_e_width"}, fall_q[0] - rise_q[0], 2);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_nib%0d", tag, i), int'(nib_q[i]), exp_nib[i]);
      if (i < 11) chk($sformatf("%s_gap%0d", tag, i), rise_q[i+1] - fall_q[i] - P_SETUP, exp_gap[i]);
      else chk($sformatf("%s_gap%0d", tag, i), rdy_rise_q[0] - fall_q[i], exp_gap[i]);
    end
  endtask

  initial begin
    int base;
    int exp_b2b[6] = '{3, 1, 3, 2, 3, 3};
    rq.req_valid = 1'b0;
    rq.req_rs    = 1'b0;
    rq.req_data  = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset_lcd_e", int'(lcd_e), 0);
    chk("reset_sf_e", int'(sf_e), 1);
    chk("reset_busy", int'(busy), 1);
    chk("reset_ready", int'(rq.req_ready), 0);

    // Request held from before reset release through the whole init
    rq.req_valid = 1'b1;
    rq.req_rs    = 1'b1;
    rq.req_data  = 8'h48;
    @(posedge clk); #1;
    release_reset();
    drive_byte(1'b1, 8'h48, 1'b0);
    wait_idle(3);
    check_init("init");
    chk("pulses_after_h", rise_q.size(), 14);
    chk("h_hi_nib", int'(nib_q[12]), 4);
    chk("h_lo_nib", int'(nib_q[13]), 8);
    chk("h_hi_rs", int'(rsl_q[12]), 1);
    chk("h_lo_rs", int'(rsl_q[13]), 1);
    chk("h_nibble_gap", rise_q[13] - fall_q[12] - P_SETUP, 3);
    chk("h_ready_drop", rdy_fall_q[0] - hs_cyc, 1);
    chk("h_ready_back", rdy_rise_q[1] - fall_q[13], 4);

    drive_byte(1'b0, 8'h01, 1'b0);
    wait_idle(2);
    chk("clear_low_wait", rdy_rise_q[$] - fall_q[$], 15);
    drive_byte(1'b0, 8'hC0, 1'b0);
    wait_idle(2);
    chk("c0_low_wait", rdy_rise_q[$] - fall_q[$], 4);
    chk("c0_hi_nib", int'(nib_q[$-1]), 12);

    base = rise_q.size();
    drive_byte(1'b1, 8'h31, 1'b1);
    drive_byte(1'b1, 8'h32, 1'b1);
    drive_byte(1'b1, 8'h33, 1'b0);
    wait_idle(4);
    chk("b2b_pulse_count", rise_q.size() - base, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("b2b_nib%0d", i), int'(nib_q[base+i]), exp_b2b[i]);
    chk("b2b_restart_gap", rise_q[base+2] - fall_q[base+1], 6);

    // Reset in the middle of a data byte's E-high window
    drive_byte(1'b1, 8'h5A, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (lcd_e) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      chk("ehigh_seen", int'(seen), 1);
    end
    #2;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_lcd_e", int'(lcd_e), 0);
    chk("async_init_done", int'(init_done), 0);
    chk("async_lcd_d", int'(lcd_d), 0);
    chk("async_lcd_rs", int'(lcd_rs), 0);
    chk("async_busy", int'(busy), 1);
    repeat (3) @(posedge clk); #1;
    release_reset();
    wait_idle(3);
    check_init("reinit");
    chk("reinit_pulses", rise_q.size(), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
